// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into header, payload and checksum,
// writes payload words to instruction memory and releases the core.
module imem_loader #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        IMEM_WE,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IMEM_WDATA,
    output logic        CORE_RESET,
    output logic        LOAD_DONE,
    output logic        LOAD_ERROR,
    output logic [31:0] WORDS_LOADED
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic [31:0] csum_q;
    logic [31:0] n_q;
    logic [31:0] cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        err_q;
    logic        core_rst_q;

    logic        xfer;
    logic        word_done;
    logic        hdr_bad;
    logic        last_word;
    logic [31:0] word;

    always_comb begin
        RX_READY  = 1'b0;
        state_d   = state_q;
        // The 4th byte is taken straight from the bus to finish the word.
        word      = {RX_DATA, asm_q};
        hdr_bad   = (word == 32'd0) || (word > 32'(DEPTH));
        last_word = (cnt_q + 32'd1) == n_q;

        unique case (state_q)
            S_HDR, S_DATA, S_CSUM: RX_READY = 1'b1;
            default:               RX_READY = 1'b0;
        endcase

        xfer      = RX_VALID && RX_READY;
        word_done = xfer && (idx_q == 2'd3);

        if (word_done) begin
            unique case (state_q)
                S_HDR:   state_d = hdr_bad ? S_ERR : S_DATA;
                S_DATA:  state_d = last_word ? S_CSUM : S_DATA;
                S_CSUM:  state_d = (word == csum_q) ? S_DONE : S_ERR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_HDR;
            idx_q      <= 2'd0;
            asm_q      <= 24'd0;
            csum_q     <= 32'd0;
            n_q        <= 32'd0;
            cnt_q      <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;

            if (xfer) begin
                idx_q <= idx_q + 2'd1;
                case (idx_q)
                    2'd0:    asm_q[7:0]   <= RX_DATA;
                    2'd1:    asm_q[15:8]  <= RX_DATA;
                    2'd2:    asm_q[23:16] <= RX_DATA;
                    default: ;
                endcase
            end

            if (word_done && state_q == S_HDR) begin
                n_q <= word;
            end

            if (word_done && state_q == S_DATA) begin
                we_q    <= 1'b1;
                addr_q  <= BASE_ADDR + {cnt_q[29:0], 2'b00};
                wdata_q <= word;
                csum_q  <= csum_q ^ word;
                cnt_q   <= cnt_q + 32'd1;
            end

            if (state_d == S_DONE) begin
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
            end

            if (state_d == S_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign IMEM_WE      = we_q;
    assign IMEM_ADDR    = addr_q;
    assign IMEM_WDATA   = wdata_q;
    assign CORE_RESET   = core_rst_q;
    assign LOAD_DONE    = done_q;
    assign LOAD_ERROR   = err_q;
    assign WORDS_LOADED = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: word-index reference model, per-cycle compare,
// directed images plus randomized images with gaps and aborts.
module tb_imem_loader;

    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        IMEM_WE;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_WDATA;
    logic        CORE_RESET;
    logic        LOAD_DONE;
    logic        LOAD_ERROR;
    logic [31:0] WORDS_LOADED;

    imem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (RX_READY),
        .IMEM_WE      (IMEM_WE),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_WDATA   (IMEM_WDATA),
        .CORE_RESET   (CORE_RESET),
        .LOAD_DONE    (LOAD_DONE),
        .LOAD_ERROR   (LOAD_ERROR),
        .WORDS_LOADED (WORDS_LOADED)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    bit          armed = 1'b0;
    int          m_bc;
    int          m_widx;
    logic [31:0] m_cur;
    logic [31:0] m_n;
    logic [31:0] m_xor;
    logic [31:0] m_loaded;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    bit          m_done;
    bit          m_err;
    bit          m_we;

    logic [63:0] wlog[$];
    logic [7:0]  stream[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word 0 is the count, words 1..N are payload, word N+1 the checksum.
    always @(posedge CLK) begin
        if (RESET) begin
            armed    = 1'b1;
            m_bc     = 0;
            m_widx   = 0;
            m_cur    = 32'd0;
            m_n      = 32'd0;
            m_xor    = 32'd0;
            m_loaded = 32'd0;
            m_addr   = BASE;
            m_data   = 32'd0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_we     = 1'b0;
        end else if (armed) begin
            m_we = 1'b0;
            if (RX_VALID && !m_done && !m_err) begin
                m_cur[8*m_bc +: 8] = RX_DATA;
                m_bc++;
                if (m_bc == 4) begin
                    m_bc = 0;
                    if (m_widx == 0) begin
                        m_n = m_cur;
                        if (m_n == 0 || m_n > DEPTH) m_err = 1'b1;
                    end else if (m_widx <= m_n) begin
                        m_we     = 1'b1;
                        m_addr   = BASE + 32'(4 * (m_widx - 1));
                        m_data   = m_cur;
                        m_xor    = m_xor ^ m_cur;
                        m_loaded = 32'(m_widx);
                    end else if (m_cur == m_xor) begin
                        m_done = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_widx++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("rx_ready", 32'(RX_READY), 32'(!(m_done || m_err)));
            chk("imem_we", 32'(IMEM_WE), 32'(m_we));
            chk("imem_addr", IMEM_ADDR, m_addr);
            chk("imem_wdata", IMEM_WDATA, m_data);
            chk("core_reset", 32'(CORE_RESET), 32'(!m_done));
            chk("load_done", 32'(LOAD_DONE), 32'(m_done));
            chk("load_error", 32'(LOAD_ERROR), 32'(m_err));
            chk("words_loaded", WORDS_LOADED, m_loaded);
            if (IMEM_WE === 1'b1) wlog.push_back({IMEM_ADDR, IMEM_WDATA});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            RX_VALID = 1'b0;
            RX_DATA  = 8'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        RX_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        wlog.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
    endtask

    task automatic nominal_stream(input logic [31:0] cs);
        stream.delete();
        push_word(32'd2);
        push_word(32'h0050_0113);
        push_word(32'h00A0_0193);
        push_word(cs);
    endtask

    // gap_mode < 0 picks a random 0..3 idle cycles before each byte.
    task automatic send_stream(input int gap_mode, input int cut);
        for (int i = 0; i < stream.size() && i < cut; i++) begin
            idle(gap_mode < 0 ? int'($urandom_range(0, 3)) : gap_mode);
            RX_VALID = 1'b1;
            RX_DATA  = stream[i];
            @(posedge CLK);
            #1;
        end
        idle(3);
    endtask

    task automatic chk_write(input string nm, input int i,
                             input logic [31:0] a, input logic [31:0] d);
        chk({nm, "_present"}, 32'(i < wlog.size()), 32'd1);
        if (i < wlog.size()) begin
            chk({nm, "_addr"}, wlog[i][63:32], a);
            chk({nm, "_data"}, wlog[i][31:0], d);
        end
    endtask

    task automatic chk_nominal_result(input string nm);
        chk({nm, "_nwrites"}, 32'(wlog.size()), 32'd2);
        chk_write({nm, "_w0"}, 0, 32'h0, 32'h0050_0113);
        chk_write({nm, "_w1"}, 1, 32'h4, 32'h00A0_0193);
        chk({nm, "_done"}, 32'(LOAD_DONE), 32'd1);
        chk({nm, "_err"}, 32'(LOAD_ERROR), 32'd0);
        chk({nm, "_core_rst"}, 32'(CORE_RESET), 32'd0);
        chk({nm, "_loaded"}, WORDS_LOADED, 32'd2);
        chk({nm, "_ready"}, 32'(RX_READY), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        logic [31:0] x;
        logic [31:0] w;
        int          sel;
        int          cut;

        RESET    = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;

        do_reset();
        chk("rst_core_reset", 32'(CORE_RESET), 32'd1);
        chk("rst_addr", IMEM_ADDR, BASE);
        chk("rst_ready", 32'(RX_READY), 32'd1);

        // 0x00500113 ^ 0x00A00193 = 0x00F00080
        nominal_stream(32'h00F0_0080);
        send_stream(0, 1000);
        chk("model_xor", m_xor, 32'h00F0_0080);
        chk_nominal_result("nominal");

        do_reset();
        nominal_stream(32'h00F0_0081);
        send_stream(0, 1000);
        chk("badcs_nwrites", 32'(wlog.size()), 32'd2);
        chk("badcs_err", 32'(LOAD_ERROR), 32'd1);
        chk("badcs_done", 32'(LOAD_DONE), 32'd0);
        chk("badcs_core_rst", 32'(CORE_RESET), 32'd1);

        do_reset();
        nominal_stream(32'h00F0_0200);
        send_stream(0, 1000);
        chk("badcs2_err", 32'(LOAD_ERROR), 32'd1);

        for (int h = 0; h < 2; h++) begin
            do_reset();
            stream.delete();
            push_word(h == 0 ? 32'd0 : 32'd129);
            push_word(32'h0050_0113);
            send_stream(0, 1000);
            chk("badhdr_nwrites", 32'(wlog.size()), 32'd0);
            chk("badhdr_err", 32'(LOAD_ERROR), 32'd1);
            chk("badhdr_ready", 32'(RX_READY), 32'd0);
        end

        do_reset();
        nominal_stream(32'h00F0_0080);
        send_stream(3, 1000);
        chk_nominal_result("gapped");

        do_reset();
        nominal_stream(32'h00F0_0080);
        send_stream(0, 6);
        RESET    = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA  = 8'hAB;
        @(posedge CLK);
        #1;
        chk("midrst_core_rst", 32'(CORE_RESET), 32'd1);
        chk("midrst_loaded", WORDS_LOADED, 32'd0);
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        RX_VALID = 1'b0;
        wlog.delete();
        send_stream(0, 1000);
        chk_nominal_result("midrst");

        do_reset();
        stream.delete();
        push_word(32'd128);
        x = 32'd0;
        for (int k = 0; k < 128; k++) begin
            push_word(32'(k));
            x = x ^ 32'(k);
        end
        push_word(x);
        send_stream(0, 1000);
        chk("full_nwrites", 32'(wlog.size()), 32'd128);
        chk_write("full_last", 127, 32'h1FC, 32'h7F);
        chk("full_done", 32'(LOAD_DONE), 32'd1);
        chk("full_loaded", WORDS_LOADED, 32'd128);

        for (int it = 0; it < 24; it++) begin
            do_reset();
            stream.delete();
            sel = int'($urandom_range(0, 9));
            if (sel == 0) n = 32'(DEPTH + 1 + $urandom_range(0, 5));
            else if (sel == 1) n = 32'd0;
            else n = 32'($urandom_range(1, 6));
            push_word(n);
            x = 32'd0;
            if (n >= 1 && n <= DEPTH) begin
                for (int k = 0; k < n; k++) begin
                    w = $urandom;
                    x = x ^ w;
                    push_word(w);
                end
            end
            if ($urandom_range(0, 2) == 0) x = x ^ (32'd1 << $urandom_range(0, 31));
            push_word(x);
            push_word($urandom);
            cut = ($urandom_range(0, 4) == 0)
                ? int'($urandom_range(1, stream.size()))
                : stream.size();
            send_stream(-1, cut);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
